fb_writer: RTL and testbench
============================

// Module: fb_writer
// PURPOSE
// - Downstream of the ray tracer: takes each finished pixel (ray_done, fp24_vec3 colour, h/v),
//   converts the colour to 8-bit-per-channel RGB, computes the linear framebuffer address and
//   buffers the result in a FIFO that drains to the framebuffer BRAM port over a valid/ready handshake.
// - Tracer has no backpressure: this block absorbs bursts and flags any loss.
// PARAMETERS
// - WIDTH       1280  pixels per line; addr = v*WIDTH + h
// - HEIGHT      720   lines per frame
// - FIFO_DEPTH  16    entries, power of 2, >=4
// PORTS
// - clk            in   1                     system clock
// - rst_n          in   1                     async active-low reset
// - ray_done       in   1                     pixel result valid this cycle
// - pixel_color    in   72 (fp24_vec3)        {r,g,b}, fp24 each
// - pixel_h_in     in   11                    column
// - pixel_v_in     in   10                    row
// - fb_addr        out  $clog2(WIDTH*HEIGHT)  write address
// - fb_data        out  FB_DATA_W             packed colour (24 or 16, see CONFIGURATION)
// - fb_valid       out  1                     write request
// - fb_ready       in   1                     framebuffer accepts
// - frame_done     out  1                     1-cycle pulse after last pixel written
// - overflow       out  1                     sticky: a pixel was dropped on full FIFO
// - ovf_clr        in   1                     sync clear of overflow
// - fifo_level     out  $clog2(FIFO_DEPTH)+1  current occupancy
// BEHAVIOUR
// - Reset (rst_n=0, any time, async): FIFO emptied, pipe valids cleared; all outputs 0.
// - fp24 format: [23] sign, [22:16] exp (bias 63), [15:0] mantissa; exp=0 means zero.
// - Channel conversion: sign=1 or exp=0 -> 0; exp>=63 -> 255;
//   else f = {1,mant} >> (63-exp) (17b), byte = f[15:8]; shift >=17 -> 0. No rounding.
// - Pipeline: cycle N ray_done -> N+1 inputs registered (S1) -> N+2 converted + address registered (S2)
//   -> pushed into FIFO at end of N+2. With the FIFO empty, fb_valid=1 from N+3 (show-ahead).
// - Address: v*WIDTH + h computed in S1->S2 (one registered multiply).
//   Coordinates with h>=WIDTH or v>=HEIGHT: discarded in S2. Not pushed; overflow is not set.
// - Handshake: fb_valid = !empty; fb_addr/fb_data = FIFO head, stable while fb_valid && !fb_ready.
//   Pop when fb_valid && fb_ready.
// - Full: a push while full with no same-cycle pop is dropped and overflow <= 1.
//   Push and pop together while full: both occur and level is unchanged. Same for push+pop while empty+1.
// - overflow: ovf_clr clears it; a new drop in the same cycle as ovf_clr wins (stays 1).
// - frame_done: pulses the cycle after a handshake with fb_addr == WIDTH*HEIGHT-1.
// - Back-to-back ray_done on consecutive cycles is fully supported, one pixel per cycle.
// CONFIGURATION
// - FB_WRITER_RGB565_EN defined: FB_DATA_W=16, fb_data = {r[7:3], g[7:2], b[7:3]}.
// - FB_WRITER_RGB565_EN undefined: FB_DATA_W=24, fb_data = {r, g, b}.
//   FIFO width follows FB_DATA_W; no other behavioural change.
// STRUCTURE
// - Shared package (already home of fp24/fp24_vec3):
//   - add FP24_EXP_BIAS=63
//   - add typedef rgb888 {logic [7:0] r,g,b}
// - Sub-module fp24_to_u8: combinational single-channel converter, instantiated 3x in S1->S2.
// - FIFO: inline circular buffer. Pointers carry an extra wrap bit for full/empty detection.
// TESTING
// - Colours: 0x3f0000/0x3e0000/0xbf0000 -> byte 0xFF/0x80/0x00; 0x400000 -> 0xFF; 0x3e8000 -> 0xC0.
// - Single pixel (h=5, v=2, WIDTH=1280), fb_ready=1, ray_done at N:
//   fb_valid high at N+3 only, fb_addr=2565.
// - fb_ready=0, 20 consecutive ray_done, FIFO_DEPTH=16:
//   fifo_level=16, overflow=1, first 16 drain in order; ovf_clr -> overflow=0.
// - RGB565 build, colour (1.0, 0.5, 0.0) -> fb_data=0xFC00; 888 build -> 0xFF8000.
// - Write pixel (1279,719) with fb_ready=1: frame_done pulses 1 cycle after handshake;
//   h=1280 input is never written.
// - Assert rst_n mid-burst (level 7): outputs 0 immediately; no writes after release until new ray_done.

Source files
------------

// File: rtl/fb_writer_pkg.sv
// Shared types for the ray tracer back end: fp24 scalars/vectors, packed RGB,
// and the framebuffer word width, which depends on FB_WRITER_RGB565_EN
// (defined: 16-bit RGB565 words, undefined: 24-bit RGB888 words).
package fb_writer_pkg;

    localparam int FP24_EXP_BIAS = 63;

    // fp24: [23] sign, [22:16] biased exponent, [15:0] mantissa; exp==0 is zero
    typedef logic [23:0] fp24;

    typedef struct packed {
        fp24 r;
        fp24 g;
        fp24 b;
    } fp24_vec3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888;

`ifdef FB_WRITER_RGB565_EN
    localparam int FB_DATA_W = 16;
`else
    localparam int FB_DATA_W = 24;
`endif

    // Pack an 8-bit-per-channel colour into the framebuffer word layout
    function automatic logic [FB_DATA_W-1:0] pack_rgb(input rgb888 c);
`ifdef FB_WRITER_RGB565_EN
        return {c.r[7:3], c.g[7:2], c.b[7:3]};
`else
        return {c.r, c.g, c.b};
`endif
    endfunction

endpackage

// File: rtl/fb_writer_if.sv
// Framebuffer write port bundle: address/data qualified by a valid/ready pair.
interface fb_writer_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 24
);
    // Handshake: a word transfers on every rising clock edge where fb_valid and
    // fb_ready are both 1. Once fb_valid is raised, fb_addr/fb_data hold steady
    // and fb_valid stays high until that transfer happens; fb_ready may change
    // freely and has no combinational dependency on fb_valid.
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_data;
    logic              fb_valid;
    logic              fb_ready;

    modport master (
        output fb_addr,
        output fb_data,
        output fb_valid,
        input  fb_ready
    );

    modport slave (
        input  fb_addr,
        input  fb_data,
        input  fb_valid,
        output fb_ready
    );
endinterface

// File: rtl/fb_writer_fp24_to_u8.sv
// fp24_to_u8: combinational fp24 -> unsigned 8-bit channel converter.
// Negative or zero maps to 0, values >= 1.0 saturate to 255, everything else
// is truncated (no rounding) from the fixed-point fraction.
module fb_writer_fp24_to_u8
    import fb_writer_pkg::*;
(
    input  fp24        i_val,
    output logic [7:0] o_byte
);

    logic [6:0] w_exp;
    logic [6:0] w_shift;
    logic [7:0] w_frac_byte;

    assign w_exp       = i_val[22:16];
    // Only meaningful when w_exp < bias; the saturating cases are caught below
    assign w_shift     = 7'(FP24_EXP_BIAS) - w_exp;
    // 1.0 sits at bit 16 of {1,mant}; the byte is bits [15:8] after alignment
    assign w_frac_byte = 8'(({1'b1, i_val[15:0]} >> w_shift) >> 8);

    // Select zero, saturation or the aligned fraction byte
    always_comb begin
        o_byte = w_frac_byte;
        if (i_val[23] || (w_exp == 7'd0)) begin
            o_byte = 8'd0;
        end else if (w_exp >= 7'(FP24_EXP_BIAS)) begin
            o_byte = 8'hFF;
        end else if (w_shift >= 7'd17) begin
            o_byte = 8'd0;
        end
    end

endmodule

// File: rtl/fb_writer.sv
// fb_writer: converts finished pixels to packed RGB, computes the linear
// framebuffer address and queues them in a FIFO draining to the framebuffer.
// Pipeline: S1 registers the tracer outputs, S2 registers converted colour and
// address, the S2 word is pushed into the FIFO at the end of its cycle.
// Word format is selected by FB_WRITER_RGB565_EN (see fb_writer_pkg).
module fb_writer
    import fb_writer_pkg::*;
#(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int FIFO_DEPTH = 16,
    localparam int ADDR_W    = $clog2(WIDTH * HEIGHT),
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ray_done,
    input  fp24_vec3         pixel_color,
    input  logic [10:0]      pixel_h_in,
    input  logic [9:0]       pixel_v_in,
    fb_writer_if.master      fb,
    output logic             frame_done,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    // ---------------- S1: registered tracer outputs ----------------
    logic             r_s1_valid;
    fp24_vec3         r_s1_color;
    logic [10:0]      r_s1_h;
    logic [9:0]       r_s1_v;

    // Capture a pixel whenever the tracer reports one (no backpressure)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_color <= '0;
            r_s1_h     <= '0;
            r_s1_v     <= '0;
        end else begin
            r_s1_valid <= ray_done;
            if (ray_done) begin
                r_s1_color <= pixel_color;
                r_s1_h     <= pixel_h_in;
                r_s1_v     <= pixel_v_in;
            end
        end
    end

    // ---------------- S1 -> S2: convert colour, form address ----------------
    logic [7:0]             w_r_u8;
    logic [7:0]             w_g_u8;
    logic [7:0]             w_b_u8;
    rgb888                  w_rgb;
    logic [ADDR_W-1:0]      w_addr;
    logic                   w_in_frame;

    fb_writer_fp24_to_u8 u_conv_r (.i_val(r_s1_color.r), .o_byte(w_r_u8));
    fb_writer_fp24_to_u8 u_conv_g (.i_val(r_s1_color.g), .o_byte(w_g_u8));
    fb_writer_fp24_to_u8 u_conv_b (.i_val(r_s1_color.b), .o_byte(w_b_u8));

    assign w_rgb      = '{r: w_r_u8, g: w_g_u8, b: w_b_u8};
    assign w_addr     = ADDR_W'(r_s1_v) * ADDR_W'(WIDTH) + ADDR_W'(r_s1_h);
    // Off-screen coordinates are silently dropped; they are not FIFO losses
    assign w_in_frame = (int'(r_s1_h) < WIDTH) && (int'(r_s1_v) < HEIGHT);

    logic                   r_s2_valid;
    logic [ADDR_W-1:0]      r_s2_addr;
    logic [FB_DATA_W-1:0]   r_s2_data;

    // Register the converted word and its address; off-screen pixels lose valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_data  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid && w_in_frame;
            if (r_s1_valid) begin
                r_s2_addr <= w_addr;
                r_s2_data <= pack_rgb(w_rgb);
            end
        end
    end

    // ---------------- FIFO: circular buffer with wrap-bit pointers ----------------
    logic [ADDR_W-1:0]      r_mem_addr [FIFO_DEPTH];
    logic [FB_DATA_W-1:0]   r_mem_data [FIFO_DEPTH];
    logic [IDX_W:0]         r_wr_ptr;
    logic [IDX_W:0]         r_rd_ptr;
    logic [LVL_W-1:0]       w_level;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == LVL_W'(FIFO_DEPTH));
    assign w_pop   = !w_empty && fb.fb_ready;
    // A push into a full FIFO still succeeds when the head leaves the same cycle
    assign w_push  = r_s2_valid && (!w_full || w_pop);
    assign w_drop  = r_s2_valid && w_full && !w_pop;

    // Storage array: written at the tail, no reset needed (guarded by pointers)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr[IDX_W-1:0]] <= r_s2_addr;
            r_mem_data[r_wr_ptr[IDX_W-1:0]] <= r_s2_data;
        end
    end

    // Advance tail on push and head on pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Show-ahead head; forced to zero while empty so outputs are 0 after reset
    assign fb.fb_valid = !w_empty;
    assign fb.fb_addr  = w_empty ? '0 : r_mem_addr[r_rd_ptr[IDX_W-1:0]];
    assign fb.fb_data  = w_empty ? '0 : r_mem_data[r_rd_ptr[IDX_W-1:0]];
    assign fifo_level  = w_level;

    // ---------------- status ----------------
    logic r_frame_done;
    logic r_overflow;

    // Pulse one cycle after the last pixel of the frame is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_pop && (fb.fb_addr == LAST_ADDR);
        end
    end

    // Sticky loss flag; a drop in the same cycle as the clear keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: table of single-pixel vectors plus
// hand-written burst, full-FIFO, overflow-clear and reset sequences.
module tb_fb_writer;
    import fb_writer_pkg::*;

    localparam int ADDR_W = 20;
    localparam int LVL_W  = 5;
    localparam int DW     = FB_DATA_W;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ray_done = 1'b0;
    fp24_vec3         pixel_color = '0;
    logic [10:0]      pixel_h_in = '0;
    logic [9:0]       pixel_v_in = '0;
    logic             ovf_clr = 1'b0;
    logic             frame_done;
    logic             overflow;
    logic [LVL_W-1:0] fifo_level;

    fb_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DW)) fb ();

    fb_writer #(.WIDTH(1280), .HEIGHT(720), .FIFO_DEPTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ray_done    (ray_done),
        .pixel_color (pixel_color),
        .pixel_h_in  (pixel_h_in),
        .pixel_v_in  (pixel_v_in),
        .fb          (fb.master),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [ADDR_W+DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_pack(input logic [7:0] r, input logic [7:0] g,
                                               input logic [7:0] b);
`ifdef FB_WRITER_RGB565_EN
        return {r[7:3], g[7:2], b[7:3]};
`else
        return {r, g, b};
`endif
    endfunction

    task automatic expect_word(input int addr, input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b);
        exp_q.push_back({ADDR_W'(addr), exp_pack(r, g, b)});
    endtask

    // ---------------- driver ----------------
    // One cycle: at the falling edge, score any transfer about to happen on the
    // next rising edge, then drive the inputs for that edge.
    task automatic step(input bit rd, input fp24_vec3 col, input int hh, input int vv,
                        input bit rdy, input bit clr);
        logic [ADDR_W+DW-1:0] e;
        @(negedge clk);
        if (fb.fb_valid && rdy) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                         fb.fb_addr, fb.fb_data);
            end else begin
                e = exp_q.pop_front();
                check("fb_addr", 64'(fb.fb_addr), 64'(e[ADDR_W+DW-1:DW]));
                check("fb_data", 64'(fb.fb_data), 64'(e[DW-1:0]));
            end
        end
        ray_done    = rd;
        pixel_color = col;
        pixel_h_in  = 11'(hh);
        pixel_v_in  = 10'(vv);
        fb.fb_ready = rdy;
        ovf_clr     = clr;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) step(1'b0, '0, 0, 0, rdy, 1'b0);
    endtask

    // Burst colour: r=1.0, g=0.5+k/32 (byte 0x80+8k), b=0
    function automatic fp24_vec3 burst_col(input int k);
        fp24_vec3 c;
        c.r = 24'h3f0000;
        c.g = {1'b0, 7'h3e, 4'(k), 12'h000};
        c.b = 24'h000000;
        return c;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [23:0] cr, cg, cb;
        int          h, v;
        bit          wr;
        int          addr;
        logic [7:0]  er, eg, eb;
        bit          fdone;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fp24_vec3 col;
        fb.fb_ready = 1'b0;

        vecs[0] = '{24'h3f0000, 24'h3e0000, 24'hbf0000,    5,   2, 1,   2565, 8'hFF, 8'h80, 8'h00, 0};
        vecs[1] = '{24'h400000, 24'h3e8000, 24'h000000,    0,   0, 1,      0, 8'hFF, 8'hC0, 8'h00, 0};
        vecs[2] = '{24'h3d0000, 24'h3e4000, 24'h2f0000, 1279,   0, 1,   1279, 8'h40, 8'hA0, 8'h00, 0};
        vecs[3] = '{24'h7f0000, 24'h3fffff, 24'h2e0000,    0, 719, 1, 920320, 8'hFF, 8'hFF, 8'h00, 0};
        vecs[4] = '{24'h010000, 24'h3effff, 24'h3c8000,  640, 360, 1, 461440, 8'h00, 8'hFF, 8'h30, 0};
        vecs[5] = '{24'h3f0000, 24'h3f0000, 24'h3f0000, 1279, 719, 1, 921599, 8'hFF, 8'hFF, 8'hFF, 1};
        vecs[6] = '{24'h3f0000, 24'h3f0000, 24'h3f0000, 1280,   0, 0,      0, 8'h00, 8'h00, 8'h00, 0};
        vecs[7] = '{24'h3f0000, 24'h3f0000, 24'h3f0000,    0, 720, 0,      0, 8'h00, 8'h00, 8'h00, 0};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_fb_valid", 64'(fb.fb_valid), 64'd0);
        check("rst_fb_addr", 64'(fb.fb_addr), 64'd0);
        check("rst_fb_data", 64'(fb.fb_data), 64'd0);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        rst_n = 1'b1;

        // ---- table: single pixels, fb_ready=1 ----
        for (int i = 0; i < 8; i++) begin
            col = '{r: vecs[i].cr, g: vecs[i].cg, b: vecs[i].cb};
            if (vecs[i].wr) expect_word(vecs[i].addr, vecs[i].er, vecs[i].eg, vecs[i].eb);
            step(1'b1, col, vecs[i].h, vecs[i].v, 1'b1, 1'b0);
            step(1'b0, '0, 0, 0, 1'b1, 1'b0);
            check($sformatf("v%0d_valid_n1", i), 64'(fb.fb_valid), 64'd0);
            step(1'b0, '0, 0, 0, 1'b1, 1'b0);
            check($sformatf("v%0d_valid_n2", i), 64'(fb.fb_valid), 64'd0);
            step(1'b0, '0, 0, 0, 1'b1, 1'b0);
            check($sformatf("v%0d_valid_n3", i), 64'(fb.fb_valid), 64'(vecs[i].wr));
            step(1'b0, '0, 0, 0, 1'b1, 1'b0);
            check($sformatf("v%0d_valid_n4", i), 64'(fb.fb_valid), 64'd0);
            check($sformatf("v%0d_frame_done", i), 64'(frame_done), 64'(vecs[i].fdone));
            step(1'b0, '0, 0, 0, 1'b1, 1'b0);
            check($sformatf("v%0d_frame_done_end", i), 64'(frame_done), 64'd0);
            check($sformatf("v%0d_level", i), 64'(fifo_level), 64'd0);
        end
        check("table_sb_empty", 64'(exp_q.size()), 64'd0);

        // ---- 20-pixel burst with fb_ready=0: fill, drop, drain ----
        for (int k = 0; k < 20; k++) begin
            if (k < 16) expect_word(1280 + k, 8'hFF, 8'(8'h80 + 8 * k), 8'h00);
            step(1'b1, burst_col(k), k, 1, 1'b0, 1'b0);
        end
        idle(3, 1'b0);
        check("burst_level_full", 64'(fifo_level), 64'd16);
        check("burst_overflow", 64'(overflow), 64'd1);
        idle(2, 1'b0);
        check("burst_overflow_sticky", 64'(overflow), 64'd1);
        check("burst_head_held", 64'(fb.fb_addr), 64'd1280);
        idle(18, 1'b1);
        check("burst_sb_empty", 64'(exp_q.size()), 64'd0);
        check("burst_drained_level", 64'(fifo_level), 64'd0);
        step(1'b0, '0, 0, 0, 1'b1, 1'b1);
        step(1'b0, '0, 0, 0, 1'b1, 1'b0);
        check("ovf_clr", 64'(overflow), 64'd0);

        // ---- simultaneous push/pop while full: no loss, level steady ----
        for (int c = 0; c < 27; c++) begin
            if (c < 24) begin
                expect_word(3 * 1280 + 200 + c, 8'hFF, 8'(8'h80 + 8 * (c % 16)), 8'h00);
                step(1'b1, burst_col(c % 16), 200 + c, 3, c >= 18, 1'b0);
            end else begin
                step(1'b0, '0, 0, 0, 1'b1, 1'b0);
            end
            if (c >= 18) check($sformatf("full_pp_level_c%0d", c), 64'(fifo_level), 64'd16);
        end
        check("full_pp_no_overflow", 64'(overflow), 64'd0);
        idle(20, 1'b1);
        check("full_pp_sb_empty", 64'(exp_q.size()), 64'd0);

        // ---- drop in the same cycle as ovf_clr keeps overflow set ----
        for (int c = 0; c < 17; c++) begin
            if (c < 16) expect_word(4 * 1280 + c, 8'hFF, 8'(8'h80 + 8 * c), 8'h00);
            step(1'b1, burst_col(c), c, 4, 1'b0, 1'b0);
        end
        step(1'b0, '0, 0, 0, 1'b0, 1'b0);
        check("pre_clr_overflow", 64'(overflow), 64'd0);
        step(1'b0, '0, 0, 0, 1'b0, 1'b1);
        step(1'b0, '0, 0, 0, 1'b0, 1'b0);
        check("drop_beats_clr", 64'(overflow), 64'd1);
        step(1'b0, '0, 0, 0, 1'b0, 1'b1);
        step(1'b0, '0, 0, 0, 1'b0, 1'b0);
        check("clr_after_drop", 64'(overflow), 64'd0);
        idle(18, 1'b1);
        check("clr_sb_empty", 64'(exp_q.size()), 64'd0);

        // ---- asynchronous reset mid-burst at level 7 ----
        for (int c = 0; c < 9; c++) step(1'b1, burst_col(c), 10 + c, 6, 1'b0, 1'b0);
        step(1'b0, '0, 0, 0, 1'b0, 1'b0);
        check("pre_reset_level", 64'(fifo_level), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(fb.fb_valid), 64'd0);
        check("async_rst_level", 64'(fifo_level), 64'd0);
        check("async_rst_addr", 64'(fb.fb_addr), 64'd0);
        check("async_rst_data", 64'(fb.fb_data), 64'd0);
        idle(2, 1'b1);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, '0, 0, 0, 1'b1, 1'b0);
            check($sformatf("post_rst_idle_%0d", k), 64'(fb.fb_valid), 64'd0);
        end
        col = '{r: 24'h3f0000, g: 24'h3e0000, b: 24'hbf0000};
        expect_word(2565, 8'hFF, 8'h80, 8'h00);
        step(1'b1, col, 5, 2, 1'b1, 1'b0);
        idle(5, 1'b1);
        check("post_rst_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
